// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, status codes, register ids,
// ALU function codes, condition codes, the E pipeline register layout and
// the branch/cmov condition evaluator.
package y86_pkg;

    // Instruction codes
    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    // Status codes
    localparam logic [3:0] SAOK = 4'h1;
    localparam logic [3:0] SHLT = 4'h2;
    localparam logic [3:0] SADR = 4'h3;
    localparam logic [3:0] SINS = 4'h4;

    // "No register" id
    localparam logic [3:0] RNONE = 4'hF;

    // ALU function codes
    localparam logic [3:0] ALUADD = 4'h0;
    localparam logic [3:0] ALUSUB = 4'h1;
    localparam logic [3:0] ALUAND = 4'h2;
    localparam logic [3:0] ALUXOR = 4'h3;

    // Condition codes (ifun of jXX / cmovXX)
    localparam logic [3:0] C_YES = 4'h0;
    localparam logic [3:0] C_LE  = 4'h1;
    localparam logic [3:0] C_L   = 4'h2;
    localparam logic [3:0] C_E   = 4'h3;
    localparam logic [3:0] C_NE  = 4'h4;
    localparam logic [3:0] C_GE  = 4'h5;
    localparam logic [3:0] C_G   = 4'h6;

    // Contents of the D->E pipeline register
    typedef struct packed {
        logic [3:0]  stat;
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [63:0] valc;
        logic [63:0] vala;
        logic [63:0] valb;
        logic [3:0]  dste;
        logic [3:0]  dstm;
        logic [3:0]  srca;
        logic [3:0]  srcb;
    } e_reg_t;

    // Bubble contents: a nop that writes nothing
    localparam e_reg_t E_BUBBLE = '{
        stat:  SAOK,
        icode: INOP,
        ifun:  4'h0,
        valc:  64'h0,
        vala:  64'h0,
        valb:  64'h0,
        dste:  RNONE,
        dstm:  RNONE,
        srca:  RNONE,
        srcb:  RNONE
    };

    // Evaluate a jXX / cmovXX condition against the stored flags
    function automatic logic cond_eval(input logic [3:0] ifun,
                                       input logic zf,
                                       input logic sf,
                                       input logic of);
        logic res;
        case (ifun)
            C_YES:   res = 1'b1;
            C_LE:    res = (sf ^ of) | zf;
            C_L:     res = sf ^ of;
            C_E:     res = zf;
            C_NE:    res = ~zf;
            C_GE:    res = ~(sf ^ of);
            C_G:     res = ~(sf ^ of) & ~zf;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/alu64.sv
// Y86-64 ALU: computes valE = B op A and the ZF/SF/OF flags of that result.
// Purely combinational.
import y86_pkg::*;

module alu64 (
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic [3:0]  fun,
    output logic [63:0] val_e,
    output logic        zf,
    output logic        sf,
    output logic        of
);

    logic [63:0] res_s;
    logic        of_s;

    // Result and overflow for the selected function; undefined functions yield 0
    always_comb begin
        res_s = 64'h0;
        of_s  = 1'b0;
        case (fun)
            ALUADD: begin
                res_s = b + a;
                of_s  = (a[63] == b[63]) && (res_s[63] != a[63]);
            end
            ALUSUB: begin
                res_s = b - a;
                of_s  = (a[63] != b[63]) && (res_s[63] != b[63]);
            end
            ALUAND: begin
                res_s = b & a;
                of_s  = 1'b0;
            end
            ALUXOR: begin
                res_s = b ^ a;
                of_s  = 1'b0;
            end
            default: begin
                res_s = 64'h0;
                of_s  = 1'b0;
            end
        endcase
    end

    assign val_e = res_s;
    assign zf    = (res_s == 64'h0);
    assign sf    = res_s[63];
    assign of    = of_s;

endmodule

// File: rtl/execute_stage.sv
// Y86-64 execute stage: D->E pipeline register, operand selection, 64-bit ALU,
// condition-code register and jXX/cmovXX condition evaluation.
import y86_pkg::*;

module execute_stage #(
    parameter int W        = 64,
    parameter int STACK_ST = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         E_bubble,
    input  logic         m_exc,
    input  logic         W_exc,
    input  logic [3:0]   d_stat,
    input  logic [3:0]   d_icode,
    input  logic [3:0]   d_ifun,
    input  logic [W-1:0] d_valC,
    input  logic [W-1:0] d_valA,
    input  logic [W-1:0] d_valB,
    input  logic [3:0]   d_dstE,
    input  logic [3:0]   d_dstM,
    input  logic [3:0]   d_srcA,
    input  logic [3:0]   d_srcB,
    output logic [3:0]   E_stat,
    output logic [3:0]   E_icode,
    output logic [3:0]   E_ifun,
    output logic [W-1:0] E_valA,
    output logic [3:0]   E_dstM,
    output logic [3:0]   E_srcA,
    output logic [3:0]   E_srcB,
    output logic [W-1:0] e_valE,
    output logic         e_Cnd,
    output logic [3:0]   e_dstE,
    output logic         cc_zf,
    output logic         cc_sf,
    output logic         cc_of
);

    localparam logic [W-1:0] STACK_STEP = W'(STACK_ST);

    e_reg_t      e_reg_r;
    logic        cc_zf_r;
    logic        cc_sf_r;
    logic        cc_of_r;

    logic [W-1:0] alu_a_s;
    logic [W-1:0] alu_b_s;
    logic [3:0]   alu_fun_s;
    logic [W-1:0] alu_vale_s;
    logic         alu_zf_s;
    logic         alu_sf_s;
    logic         alu_of_s;
    logic         set_cc_s;
    logic         cnd_s;
    logic [3:0]   dste_s;

    // E pipeline register: reset and bubble both load a nop, otherwise take decode
    always_ff @(posedge clk) begin
        if (rst) begin
            e_reg_r <= E_BUBBLE;
        end else if (E_bubble) begin
            e_reg_r <= E_BUBBLE;
        end else begin
            e_reg_r <= '{
                stat:  d_stat,
                icode: d_icode,
                ifun:  d_ifun,
                valc:  d_valC,
                vala:  d_valA,
                valb:  d_valB,
                dste:  d_dstE,
                dstm:  d_dstM,
                srca:  d_srcA,
                srcb:  d_srcB
            };
        end
    end

    // Operand and function selection from the instruction held in E
    always_comb begin
        alu_a_s   = {W{1'b0}};
        alu_b_s   = {W{1'b0}};
        alu_fun_s = ALUADD;
        case (e_reg_r.icode)
            IRRMOVQ: begin
                alu_a_s = e_reg_r.vala;
                alu_b_s = {W{1'b0}};
            end
            IIRMOVQ: begin
                alu_a_s = e_reg_r.valc;
                alu_b_s = {W{1'b0}};
            end
            IRMMOVQ, IMRMOVQ: begin
                alu_a_s = e_reg_r.valc;
                alu_b_s = e_reg_r.valb;
            end
            IOPQ: begin
                alu_a_s   = e_reg_r.vala;
                alu_b_s   = e_reg_r.valb;
                alu_fun_s = e_reg_r.ifun;
            end
            ICALL, IPUSHQ: begin
                alu_a_s = {W{1'b0}} - STACK_STEP;
                alu_b_s = e_reg_r.valb;
            end
            IRET, IPOPQ: begin
                alu_a_s = STACK_STEP;
                alu_b_s = e_reg_r.valb;
            end
            default: begin
                alu_a_s = {W{1'b0}};
                alu_b_s = {W{1'b0}};
            end
        endcase
    end

    alu64 u_alu (
        .a     (alu_a_s),
        .b     (alu_b_s),
        .fun   (alu_fun_s),
        .val_e (alu_vale_s),
        .zf    (alu_zf_s),
        .sf    (alu_sf_s),
        .of    (alu_of_s)
    );

    // Only a healthy OPq with no exception further down the pipe may touch CC
    assign set_cc_s = (e_reg_r.icode == IOPQ) && (e_reg_r.stat == SAOK) && !m_exc && !W_exc;

    // Condition-code register, written at the end of the OPq's E cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            cc_zf_r <= 1'b1;
            cc_sf_r <= 1'b0;
            cc_of_r <= 1'b0;
        end else if (set_cc_s) begin
            cc_zf_r <= alu_zf_s;
            cc_sf_r <= alu_sf_s;
            cc_of_r <= alu_of_s;
        end else begin
            cc_zf_r <= cc_zf_r;
            cc_sf_r <= cc_sf_r;
            cc_of_r <= cc_of_r;
        end
    end

    // Condition from stored flags; a failed cmov drops its register write
    always_comb begin
        cnd_s  = cond_eval(e_reg_r.ifun, cc_zf_r, cc_sf_r, cc_of_r);
        dste_s = e_reg_r.dste;
        if ((e_reg_r.icode == IRRMOVQ) && !cnd_s) begin
            dste_s = RNONE;
        end else begin
            dste_s = e_reg_r.dste;
        end
    end

    assign E_stat  = e_reg_r.stat;
    assign E_icode = e_reg_r.icode;
    assign E_ifun  = e_reg_r.ifun;
    assign E_valA  = e_reg_r.vala;
    assign E_dstM  = e_reg_r.dstm;
    assign E_srcA  = e_reg_r.srca;
    assign E_srcB  = e_reg_r.srcb;
    assign e_valE  = alu_vale_s;
    assign e_Cnd   = cnd_s;
    assign e_dstE  = dste_s;
    assign cc_zf   = cc_zf_r;
    assign cc_sf   = cc_sf_r;
    assign cc_of   = cc_of_r;

endmodule

// File: tb/tb_execute_stage.sv
// Bench for execute_stage: a directed vector table for the named scenarios,
// then randomized instructions checked against a behavioural model.
module tb_execute_stage;

    logic        clk = 1'b0;
    logic        rst, E_bubble, m_exc, W_exc;
    logic [3:0]  d_stat, d_icode, d_ifun, d_dstE, d_dstM, d_srcA, d_srcB;
    logic [63:0] d_valC, d_valA, d_valB;
    logic [3:0]  E_stat, E_icode, E_ifun, E_dstM, E_srcA, E_srcB, e_dstE;
    logic [63:0] E_valA, e_valE;
    logic        e_Cnd, cc_zf, cc_sf, cc_of;

    int n_vec  = 0;
    int n_fail = 0;

    execute_stage #(.W(64), .STACK_ST(8)) dut (
        .clk(clk), .rst(rst), .E_bubble(E_bubble), .m_exc(m_exc), .W_exc(W_exc),
        .d_stat(d_stat), .d_icode(d_icode), .d_ifun(d_ifun),
        .d_valC(d_valC), .d_valA(d_valA), .d_valB(d_valB),
        .d_dstE(d_dstE), .d_dstM(d_dstM), .d_srcA(d_srcA), .d_srcB(d_srcB),
        .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun), .E_valA(E_valA),
        .E_dstM(E_dstM), .E_srcA(E_srcA), .E_srcB(E_srcB),
        .e_valE(e_valE), .e_Cnd(e_Cnd), .e_dstE(e_dstE),
        .cc_zf(cc_zf), .cc_sf(cc_sf), .cc_of(cc_of)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [3:0]  stat, ic, fn, de, dm, sa, sb;
        logic [63:0] vc, va, vb;
    } me_t;

    me_t        m_e;
    logic [2:0] m_cc;   // {zf, sf, of}

    function automatic void ref_alu(input me_t e, output logic [63:0] r,
                                    output logic z, output logic s, output logic o);
        longint sa, sb, sr;
        logic [63:0] a, b;
        logic [3:0]  op;
        a = 64'd0; b = 64'd0;
        case (e.ic)
            4'h2: begin a = e.va; b = 64'd0; end
            4'h3: begin a = e.vc; b = 64'd0; end
            4'h4, 4'h5: begin a = e.vc; b = e.vb; end
            4'h6: begin a = e.va; b = e.vb; end
            4'h8, 4'hA: begin a = 64'hFFFF_FFFF_FFFF_FFF8; b = e.vb; end
            4'h9, 4'hB: begin a = 64'd8; b = e.vb; end
            default: begin a = 64'd0; b = 64'd0; end
        endcase
        op = (e.ic == 4'h6) ? e.fn : 4'h0;
        sa = a; sb = b;
        o = 1'b0;
        case (op)
            4'h0: begin
                r = b + a; sr = r;
                o = (sa >= 0 && sb >= 0 && sr < 0) || (sa < 0 && sb < 0 && sr >= 0);
            end
            4'h1: begin
                r = b - a; sr = r;
                o = (sb >= 0 && sa < 0 && sr < 0) || (sb < 0 && sa >= 0 && sr >= 0);
            end
            4'h2: r = b & a;
            4'h3: r = b ^ a;
            default: r = 64'd0;
        endcase
        z = (r == 64'd0);
        sr = r;
        s = (sr < 0);
    endfunction

    function automatic logic ref_cnd(input logic [3:0] fn, input logic [2:0] cc);
        logic z, s, o;
        z = cc[2]; s = cc[1]; o = cc[0];
        case (fn)
            4'h0: return 1'b1;
            4'h1: return (s != o) || z;
            4'h2: return s != o;
            4'h3: return z;
            4'h4: return !z;
            4'h5: return s == o;
            4'h6: return (s == o) && !z;
            default: return 1'b0;
        endcase
    endfunction

    // Advance the model by one clock edge using the inputs currently driven
    task automatic model_step();
        logic [63:0] r;
        logic z, s, o;
        ref_alu(m_e, r, z, s, o);
        if (rst) m_cc = 3'b100;
        else if (m_e.ic == 4'h6 && m_e.stat == 4'h1 && !m_exc && !W_exc) m_cc = {z, s, o};
        if (rst || E_bubble) begin
            m_e = '{stat: 4'h1, ic: 4'h1, fn: 4'h0, de: 4'hF, dm: 4'hF, sa: 4'hF, sb: 4'hF,
                    vc: 64'd0, va: 64'd0, vb: 64'd0};
        end else begin
            m_e = '{stat: d_stat, ic: d_icode, fn: d_ifun, de: d_dstE, dm: d_dstM,
                    sa: d_srcA, sb: d_srcB, vc: d_valC, va: d_valA, vb: d_valB};
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        rst, bub, mx, wx;
        logic [3:0]  ic, fn;
        logic [63:0] vc, va, vb;
        logic [3:0]  de;
        logic [63:0] x_vale;
        logic        x_cnd;
        logic [3:0]  x_dste;
        logic [2:0]  x_cc;
        logic [3:0]  x_ic;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic bb, input logic mx, input logic wx,
                       input logic [3:0] ic, input logic [3:0] fn,
                       input logic [63:0] vc, input logic [63:0] va, input logic [63:0] vb,
                       input logic [3:0] de, input logic [63:0] xv, input logic xc,
                       input logic [3:0] xd, input logic [2:0] xcc, input logic [3:0] xi);
        vec_t v;
        v = '{rst: r, bub: bb, mx: mx, wx: wx, ic: ic, fn: fn, vc: vc, va: va, vb: vb,
              de: de, x_vale: xv, x_cnd: xc, x_dste: xd, x_cc: xcc, x_ic: xi};
        tbl.push_back(v);
    endtask

    initial begin
        rst = 1'b0; E_bubble = 1'b0; m_exc = 1'b0; W_exc = 1'b0;
        d_stat = 4'h1; d_icode = 4'h1; d_ifun = 4'h0; d_dstE = 4'hF; d_dstM = 4'hF;
        d_srcA = 4'hF; d_srcB = 4'hF; d_valC = 64'd0; d_valA = 64'd0; d_valB = 64'd0;
        m_e = '{stat: 4'h1, ic: 4'h1, fn: 4'h0, de: 4'hF, dm: 4'hF, sa: 4'hF, sb: 4'hF,
                vc: 64'd0, va: 64'd0, vb: 64'd0};
        m_cc = 3'b100;

        //   rst bub mx wx  ic    fn    valC      valA   valB                    dstE   valE expected       cnd   dstE   cc{z,s,o} icode
        add(1'b1,1'b0,1'b0,1'b0, 4'h6,4'h0, 64'd0,  64'd1, 64'd2,                  4'h2, 64'd0,                1'b1, 4'hF, 3'b100, 4'h1);
        add(1'b0,1'b0,1'b0,1'b0, 4'h3,4'h0, 64'd31, 64'd0, 64'd0,                  4'h3, 64'd31,               1'b1, 4'h3, 3'b100, 4'h3);
        add(1'b0,1'b0,1'b0,1'b0, 4'h1,4'h0, 64'd0,  64'd0, 64'd0,                  4'hF, 64'd0,                1'b1, 4'hF, 3'b100, 4'h1);
        add(1'b0,1'b0,1'b0,1'b0, 4'h6,4'h1, 64'd0,  64'd5, 64'd5,                  4'h2, 64'd0,                1'b1, 4'h2, 3'b100, 4'h6);
        add(1'b0,1'b0,1'b0,1'b0, 4'h1,4'h0, 64'd0,  64'd0, 64'd0,                  4'hF, 64'd0,                1'b1, 4'hF, 3'b100, 4'h1);
        add(1'b0,1'b0,1'b0,1'b0, 4'h6,4'h0, 64'd0,  64'd1, 64'h7FFF_FFFF_FFFF_FFFF,4'h2, 64'h8000_0000_0000_0000,1'b1,4'h2, 3'b100, 4'h6);
        add(1'b0,1'b0,1'b0,1'b0, 4'h2,4'h1, 64'd0,  64'h55,64'd0,                  4'h4, 64'h55,               1'b0, 4'hF, 3'b011, 4'h2);
        add(1'b0,1'b0,1'b0,1'b0, 4'h2,4'h4, 64'd0,  64'h55,64'd0,                  4'h4, 64'h55,               1'b1, 4'h4, 3'b011, 4'h2);
        add(1'b0,1'b0,1'b0,1'b0, 4'h7,4'h6, 64'h1234,64'd0,64'd0,                  4'hF, 64'd0,                1'b1, 4'hF, 3'b011, 4'h7);
        add(1'b0,1'b0,1'b0,1'b0, 4'hA,4'h0, 64'd0,  64'd0, 64'h100,                4'h4, 64'hF8,               1'b1, 4'h4, 3'b011, 4'hA);
        add(1'b0,1'b0,1'b0,1'b0, 4'hB,4'h0, 64'd0,  64'd0, 64'h100,                4'h4, 64'h108,              1'b1, 4'h4, 3'b011, 4'hB);
        add(1'b0,1'b0,1'b0,1'b0, 4'h4,4'h0, 64'd5,  64'd0, 64'h20,                 4'hF, 64'h25,               1'b1, 4'hF, 3'b011, 4'h4);
        add(1'b0,1'b1,1'b0,1'b0, 4'h6,4'h3, 64'd0,  64'd1, 64'd1,                  4'h2, 64'd0,                1'b1, 4'hF, 3'b011, 4'h1);
        add(1'b0,1'b0,1'b0,1'b0, 4'h1,4'h0, 64'd0,  64'd0, 64'd0,                  4'hF, 64'd0,                1'b1, 4'hF, 3'b011, 4'h1);
        add(1'b0,1'b0,1'b0,1'b0, 4'h6,4'h0, 64'd0,  64'd1, 64'd1,                  4'h2, 64'd2,                1'b1, 4'h2, 3'b011, 4'h6);
        add(1'b0,1'b0,1'b1,1'b0, 4'h1,4'h0, 64'd0,  64'd0, 64'd0,                  4'hF, 64'd0,                1'b1, 4'hF, 3'b011, 4'h1);
        add(1'b0,1'b0,1'b0,1'b0, 4'h6,4'h0, 64'd0,  64'd1, 64'd1,                  4'h2, 64'd2,                1'b1, 4'h2, 3'b011, 4'h6);
        add(1'b0,1'b0,1'b0,1'b1, 4'h1,4'h0, 64'd0,  64'd0, 64'd0,                  4'hF, 64'd0,                1'b1, 4'hF, 3'b011, 4'h1);
        add(1'b0,1'b0,1'b0,1'b0, 4'h6,4'h0, 64'd0,  64'd1, 64'hFFFF_FFFF_FFFF_FFFE,4'h2, 64'hFFFF_FFFF_FFFF_FFFF,1'b1,4'h2, 3'b011, 4'h6);
        add(1'b0,1'b0,1'b0,1'b0, 4'h1,4'h0, 64'd0,  64'd0, 64'd0,                  4'hF, 64'd0,                1'b1, 4'hF, 3'b010, 4'h1);
        add(1'b0,1'b0,1'b0,1'b0, 4'h6,4'h0, 64'd0,  64'd1, 64'd1,                  4'h2, 64'd2,                1'b1, 4'h2, 3'b010, 4'h6);
        add(1'b1,1'b0,1'b0,1'b0, 4'h1,4'h0, 64'd0,  64'd0, 64'd0,                  4'hF, 64'd0,                1'b1, 4'hF, 3'b100, 4'h1);

        @(negedge clk);
        foreach (tbl[i]) begin
            rst = tbl[i].rst; E_bubble = tbl[i].bub; m_exc = tbl[i].mx; W_exc = tbl[i].wx;
            d_stat = 4'h1; d_icode = tbl[i].ic; d_ifun = tbl[i].fn;
            d_valC = tbl[i].vc; d_valA = tbl[i].va; d_valB = tbl[i].vb;
            d_dstE = tbl[i].de; d_dstM = 4'hF; d_srcA = 4'hF; d_srcB = 4'hF;
            tick();
            chk($sformatf("vec%0d_valE", i), e_valE, tbl[i].x_vale);
            chk($sformatf("vec%0d_Cnd", i), {63'd0, e_Cnd}, {63'd0, tbl[i].x_cnd});
            chk($sformatf("vec%0d_dstE", i), {60'd0, e_dstE}, {60'd0, tbl[i].x_dste});
            chk($sformatf("vec%0d_cc", i), {61'd0, cc_zf, cc_sf, cc_of}, {61'd0, tbl[i].x_cc});
            chk($sformatf("vec%0d_icode", i), {60'd0, E_icode}, {60'd0, tbl[i].x_ic});
        end

        // ---------------- randomized phase against the model ----------------
        for (int n = 0; n < 500; n++) begin
            logic [63:0] r, pick[5];
            logic z, s, o, xc;
            rst      = ($urandom_range(0, 63) == 0);
            E_bubble = ($urandom_range(0, 7) == 0);
            m_exc    = ($urandom_range(0, 7) == 0);
            W_exc    = ($urandom_range(0, 7) == 0);
            d_stat   = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'h1;
            d_icode  = 4'($urandom_range(0, 15));
            d_ifun   = ($urandom_range(0, 3) != 0) ? 4'($urandom_range(0, 6)) : 4'($urandom_range(0, 15));
            pick[0] = {$urandom, $urandom};
            pick[1] = 64'h7FFF_FFFF_FFFF_FFFF;
            pick[2] = 64'h8000_0000_0000_0000;
            pick[3] = 64'($urandom_range(0, 3));
            pick[4] = 64'hFFFF_FFFF_FFFF_FFFF;
            d_valA = pick[$urandom_range(0, 4)];
            d_valB = pick[$urandom_range(0, 4)];
            d_valC = pick[$urandom_range(0, 4)];
            d_dstE = 4'($urandom_range(0, 15));
            d_dstM = 4'($urandom_range(0, 15));
            d_srcA = 4'($urandom_range(0, 15));
            d_srcB = 4'($urandom_range(0, 15));
            tick();
            ref_alu(m_e, r, z, s, o);
            xc = ref_cnd(m_e.fn, m_cc);
            chk("rnd_valE", e_valE, r);
            chk("rnd_Cnd", {63'd0, e_Cnd}, {63'd0, xc});
            chk("rnd_dstE", {60'd0, e_dstE}, {60'd0, (m_e.ic == 4'h2 && !xc) ? 4'hF : m_e.de});
            chk("rnd_cc", {61'd0, cc_zf, cc_sf, cc_of}, {61'd0, m_cc});
            chk("rnd_fields", {36'd0, E_stat, E_icode, E_ifun, E_dstM, E_srcA, E_srcB, 4'd0},
                              {36'd0, m_e.stat, m_e.ic, m_e.fn, m_e.dm, m_e.sa, m_e.sb, 4'd0});
            chk("rnd_valA", E_valA, m_e.va);
            @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
